// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus writeback path.
// Holds the per-unit result payload stored in the requester FIFOs.
package rv32i_types;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int ROB_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [REG_W-1:0] rd_addr;
        logic [ROB_W-1:0] rob_idx;
        logic             regf_we;
    } cdb_req_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Small per-unit result FIFO feeding the CDB arbiter.
// Ready is derived by the parent from the registered count only.
module cdb_req_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  cdb_req_t      push_data,
    input  logic          pop,
    output cdb_req_t      head,
    output logic [CW-1:0] count
);

    cdb_req_t      mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB writeback slot.
// One FIFO head per cycle is popped into a registered broadcast stage.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BUF_DEPTH     = 2,
    parameter int DATA_WIDTH    = XLEN,
    parameter int ROB_IDX_WIDTH = ROB_W,
    localparam int SRC_W = $clog2(NUM_REQ),
    localparam int CW    = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ-1:0][4:0]                 req_rd_addr,
    input  logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0]   req_rob_idx,
    input  logic [NUM_REQ-1:0]                      req_regf_we,
    output logic                                    cdb_valid,
    output logic [SRC_W-1:0]                        cdb_src,
    output logic [DATA_WIDTH-1:0]                   cdb_data,
    output logic [4:0]                              cdb_rd_addr,
    output logic [ROB_IDX_WIDTH-1:0]                cdb_rob_idx,
    output logic                                    cdb_regf_we
);

    logic [NUM_REQ-1:0][CW-1:0] count;
    cdb_req_t                   head [NUM_REQ];
    logic [NUM_REQ-1:0]         non_empty;
    logic [NUM_REQ-1:0]         push;
    logic [NUM_REQ-1:0]         pop;
    logic [SRC_W-1:0]           rr_ptr;
    logic [SRC_W-1:0]           winner;
    logic                       grant_vld;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        cdb_req_t push_data;

        assign req_ready[g] = count[g] < CW'(BUF_DEPTH);
        assign non_empty[g] = count[g] != '0;
        assign push[g]      = req_valid[g] && req_ready[g];
        assign pop[g]       = grant_vld && (winner == SRC_W'(g));
        assign push_data    = '{
            data:    req_data[g],
            rd_addr: req_rd_addr[g],
            rob_idx: req_rob_idx[g],
            regf_we: req_regf_we[g]
        };

        cdb_req_fifo #(
            .DEPTH(BUF_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (push[g]),
            .push_data(push_data),
            .pop      (pop[g]),
            .head     (head[g]),
            .count    (count[g])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping mod NUM_REQ.
    always_comb begin
        int k;
        grant_vld = 1'b0;
        winner    = '0;
        k         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_vld && non_empty[k]) begin
                grant_vld = 1'b1;
                winner    = SRC_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= SRC_W'((int'(winner) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid   <= 1'b0;
            cdb_src     <= '0;
            cdb_data    <= '0;
            cdb_rd_addr <= '0;
            cdb_rob_idx <= '0;
            cdb_regf_we <= 1'b0;
        end else begin
            cdb_valid <= grant_vld;
            if (grant_vld) begin
                cdb_src     <= winner;
                cdb_data    <= head[winner].data;
                cdb_rd_addr <= head[winner].rd_addr;
                cdb_rob_idx <= head[winner].rob_idx;
                cdb_regf_we <= head[winner].regf_we;
            end else begin
                cdb_src     <= '0;
                cdb_data    <= '0;
                cdb_rd_addr <= '0;
                cdb_rob_idx <= '0;
                cdb_regf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes queue expected broadcasts,
// a negedge monitor pops and compares every cdb_valid beat.
module tb_cdb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][31:0] req_data;
    logic [3:0][4:0]  req_rd_addr;
    logic [3:0][4:0]  req_rob_idx;
    logic [3:0]       req_regf_we;
    logic             cdb_valid;
    logic [1:0]       cdb_src;
    logic [31:0]      cdb_data;
    logic [4:0]       cdb_rd_addr;
    logic [4:0]       cdb_rob_idx;
    logic             cdb_regf_we;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [4:0]  rob;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   k[4];

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_rd_addr(req_rd_addr),
        .req_rob_idx(req_rob_idx),
        .req_regf_we(req_regf_we),
        .cdb_valid  (cdb_valid),
        .cdb_src    (cdb_src),
        .cdb_data   (cdb_data),
        .cdb_rd_addr(cdb_rd_addr),
        .cdb_rob_idx(cdb_rob_idx),
        .cdb_regf_we(cdb_regf_we)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [31:0] d, logic [4:0] rd,
                           logic [4:0] rob, logic we);
        req_valid[i]   = 1'b1;
        req_data[i]    = d;
        req_rd_addr[i] = rd;
        req_rob_idx[i] = rob;
        req_regf_we[i] = we;
    endtask

    task automatic expect_bc(logic [1:0] s, logic [31:0] d, logic [4:0] rd,
                             logic [4:0] rob, logic we);
        exp_t e;
        e.src  = s;
        e.data = d;
        e.rd   = rd;
        e.rob  = rob;
        e.we   = we;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (cdb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bc got src %0d data %0h want none",
                         cdb_src, cdb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bc_src", cdb_src, e.src);
                chk("bc_data", cdb_data, e.data);
                chk("bc_rd", cdb_rd_addr, e.rd);
                chk("bc_rob", cdb_rob_idx, e.rob);
                chk("bc_we", cdb_regf_we, e.we);
            end
        end
    end

    initial begin
        logic [3:0] rdy;
        logic [3:0] exp_rdy;
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_rd_addr = '0;
        req_rob_idx = '0;
        req_regf_we = '0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_valid", cdb_valid, 0);
        chk("rst_src", cdb_src, 0);
        chk("rst_data", cdb_data, 0);
        chk("rst_rob", cdb_rob_idx, 0);
        chk("rst_ready", req_ready, 4'hF);

        // single alu push: visible two edges later, idle after
        expect_bc(0, 32'h1234, 5, 3, 1);
        set_req(0, 32'h1234, 5, 3, 1);
        step();
        req_valid = '0;
        chk("t1_lat1", cdb_valid, 0);
        step();
        chk("t1_lat2", cdb_valid, 1);
        step();
        chk("t1_idle", cdb_valid, 0);
        chk("t1_idle_data", cdb_data, 0);

        // mul back-to-back
        expect_bc(1, 32'hA, 2, 4, 1);
        expect_bc(1, 32'hB, 2, 5, 1);
        set_req(1, 32'hA, 2, 4, 1);
        step();
        set_req(1, 32'hB, 2, 5, 1);
        step();
        req_valid = '0;
        chk("t3_a_valid", cdb_valid, 1);
        step();
        chk("t3_b_valid", cdb_valid, 1);
        step();
        chk("t3_idle", cdb_valid, 0);

        // branch result without register write
        expect_bc(2, 32'h55, 0, 7, 0);
        set_req(2, 32'h55, 0, 7, 0);
        step();
        req_valid = '0;
        step();
        chk("t6_valid", cdb_valid, 1);
        chk("t6_we", cdb_regf_we, 0);
        chk("t6_rob", cdb_rob_idx, 7);
        step();

        // flush with three FIFOs loaded and a push in flight
        set_req(0, 32'hDEAD0, 1, 9, 1);
        set_req(1, 32'hDEAD1, 2, 10, 1);
        set_req(2, 32'hDEAD2, 3, 11, 1);
        step();
        req_valid = '0;
        chk("t5_pre_valid", cdb_valid, 0);
        flush = 1'b1;
        set_req(3, 32'hBAD, 4, 12, 1);
        step();
        flush = 1'b0;
        req_valid = '0;
        chk("t5_valid", cdb_valid, 0);
        chk("t5_ready", req_ready, 4'hF);
        step();
        chk("t5_quiet1", cdb_valid, 0);
        step();
        chk("t5_quiet2", cdb_valid, 0);

        // rr pointer back at 0 after flush: alu wins before mem
        expect_bc(0, 32'h600, 1, 1, 1);
        expect_bc(3, 32'h603, 4, 2, 1);
        set_req(0, 32'h600, 1, 1, 1);
        set_req(3, 32'h603, 4, 2, 1);
        step();
        req_valid = '0;
        step();
        chk("t5_rr_first", cdb_src, 0);
        step();
        chk("t5_rr_second", cdb_src, 3);
        step();

        // reset mid-stream drops the pending mul result
        expect_bc(0, 32'h700, 1, 8, 1);
        set_req(0, 32'h700, 1, 8, 1);
        set_req(1, 32'h701, 2, 9, 1);
        step();
        req_valid = '0;
        step();
        chk("rm_valid", cdb_valid, 1);
        rst = 1'b1;
        step();
        chk("rm_valid0", cdb_valid, 0);
        chk("rm_data0", cdb_data, 0);
        chk("rm_rob0", cdb_rob_idx, 0);
        chk("rm_ready", req_ready, 4'hF);
        rst = 1'b0;
        step();
        chk("rm_quiet1", cdb_valid, 0);
        step();
        chk("rm_quiet2", cdb_valid, 0);

        // all four push every cycle: grants rotate, ready one-hot after fill
        for (int m = 0; m < 15; m++) begin
            logic [1:0] s;
            logic [4:0] r;
            s = 2'(m % 4);
            r = 5'(m / 4);
            expect_bc(s, (32'(s) << 8) | 32'(r), 5'(s) + 5'd1,
                      5'(s) * 5'd4 + r, 1'b1);
        end
        for (int i = 0; i < 4; i++) k[i] = 0;
        for (int n = 1; n <= 9; n++) begin
            rdy = req_ready;
            for (int i = 0; i < 4; i++) begin
                set_req(i, (32'(i) << 8) | 32'(k[i]), 5'(i + 1),
                        5'(i * 4 + k[i]), 1'b1);
            end
            step();
            for (int i = 0; i < 4; i++) begin
                if (rdy[i]) k[i]++;
            end
            exp_rdy = (n == 1) ? 4'hF : 4'(1 << ((n - 2) % 4));
            chk($sformatf("t2_ready_e%0d", n), req_ready, exp_rdy);
        end
        req_valid = '0;
        for (int i = 0; i < 10; i++) step();
        chk("t2_k0", k[0], 4);
        chk("t2_k3", k[3], 3);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
